// File: rtl/ht1080z_spi_pkg.sv
// ht1080z_spi_pkg: FSM states, default command bytes and status saturation helper for the SPI upload block
package ht1080z_spi_pkg;
  typedef enum logic [2:0] {IDLE, CMD, STATUS_TX, READ_TX, IGNORE} state_t;
  localparam logic [7:0] DEF_CMD_STATUS = 8'h55;
  localparam logic [7:0] DEF_CMD_READ = 8'h56;
  function automatic logic [6:0] sat7(input logic [31:0] v);
    return (v > 32'd127) ? 7'h7f : v[6:0];
  endfunction
endpackage

// File: rtl/ht1080z_sync_fifo.sv
// ht1080z_sync_fifo: single-clock FIFO (clk, rst, push/din, pop/dout show-ahead head, level, full, empty)
module ht1080z_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/ht1080z_spi_upload.sv
// ht1080z_spi_upload: SPI mode-0 slave returning status or FIFO bytes to the MCU (clk_sys/reset, spi_* pins, wr_* push port, fifo_level, underrun)
module ht1080z_spi_upload
  import ht1080z_spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter logic [7:0] CMD_STATUS = DEF_CMD_STATUS,
  parameter logic [7:0] CMD_READ = DEF_CMD_READ
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        spi_sck,
  input  logic                        spi_ss_n,
  input  logic                        spi_di,
  output logic                        spi_do,
  output logic                        spi_do_oe,
  input  logic [7:0]                  wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun
);
  logic [2:0] sck_s;
  logic [1:0] ss_s, di_s;
  logic rise, fall, ss, di;
  state_t state, state_n;
  logic [2:0] cnt;
  logic [7:0] shreg, cmd_byte, status_byte, fifo_dout;
  logic rep, byte_done, load_status, load_read, pop, clr, und_snap, full, empty, tx;
  ht1080z_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk_sys), .rst(reset), .push(wr_valid), .din(wr_data), .pop(pop),
    .dout(fifo_dout), .level(fifo_level), .full(full), .empty(empty)
  );
  assign wr_ready = ~full;
  assign rise = sck_s[1] & ~sck_s[2];
  assign fall = ~sck_s[1] & sck_s[2];
  assign ss = ss_s[1];
  assign di = di_s[1];
  assign tx = state == STATUS_TX || state == READ_TX;
  assign cmd_byte = {shreg[6:0], di};
  assign byte_done = !ss && rise && cnt == 3'd7;
  assign load_status = byte_done && ((state == CMD && cmd_byte == CMD_STATUS) || state == STATUS_TX);
  assign load_read = byte_done && ((state == CMD && cmd_byte == CMD_READ) || state == READ_TX);
  assign pop = load_read && !empty;
  // The completing status byte clears underrun, so a back-to-back snapshot must already see it cleared
  assign clr = byte_done && state == STATUS_TX && rep;
  assign und_snap = underrun & ~clr;
  assign status_byte = {und_snap, sat7(32'(fifo_level))};
  always_comb
    state_n = ss ? IDLE :
              state == IDLE ? CMD :
              (state == CMD && byte_done) ? (cmd_byte == CMD_STATUS ? STATUS_TX :
                                             cmd_byte == CMD_READ ? READ_TX : IGNORE) :
              state;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      sck_s <= '0;
      ss_s <= 2'b11;
      di_s <= '0;
      spi_do_oe <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sck_s <= {sck_s[1:0], spi_sck};
      ss_s <= {ss_s[0], spi_ss_n};
      di_s <= {di_s[0], spi_di};
      spi_do_oe <= ~ss;
      underrun <= (load_read && empty) | und_snap;
    end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      cnt <= '0;
      shreg <= '0;
      rep <= 1'b0;
      spi_do <= 1'b0;
    end else if (ss) begin
      cnt <= '0;
      shreg <= '0;
      rep <= 1'b0;
      spi_do <= 1'b0;
    end else begin
      if (rise && state != IDLE) cnt <= cnt + 3'd1;
      if (load_status) begin
        shreg <= status_byte;
        rep <= und_snap;
      end else if (load_read) shreg <= pop ? fifo_dout : 8'h00;
      else if (rise && state == CMD) shreg <= cmd_byte;
      else if (fall && tx) shreg <= shreg << 1;
      if (fall) spi_do <= tx & shreg[7];
    end
endmodule

// File: tb/tb_ht1080z_spi_upload.sv
// tb_ht1080z_spi_upload: randomized scoreboard bench for ht1080z_spi_upload against a byte-level model
module tb_ht1080z_spi_upload;
  localparam int DEPTH = 16;
  localparam int H = 8;
  logic clk_sys = 0, reset = 1, spi_sck = 0, spi_ss_n = 1, spi_di = 0;
  logic spi_do, spi_do_oe, wr_valid = 0, wr_ready, underrun;
  logic [7:0] wr_data = 0;
  logic [$clog2(DEPTH):0] fifo_level;
  int n_chk = 0, n_fail = 0;
  logic [7:0] mq[$];
  logic [7:0] exq[$];
  logic m_und = 0;
  logic rx_en = 0;
  logic [7:0] rx_sh = 0;
  int rx_n = 0;

  ht1080z_spi_upload #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .reset(reset), .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_di(spi_di),
    .spi_do(spi_do), .spi_do_oe(spi_do_oe), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .fifo_level(fifo_level), .underrun(underrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge spi_sck) begin
    if (!rx_en) rx_n = 0;
    else begin
      rx_sh = {rx_sh[6:0], spi_do};
      rx_n++;
      if (rx_n == 8) begin
        rx_n = 0;
        if (exq.size() == 0) check("miso_unexpected_byte", rx_sh, 32'hffff_ffff);
        else check("miso_byte", rx_sh, exq.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1;
    spi_ss_n = 1;
    spi_sck = 0;
    wr_valid = 0;
    rx_en = 0;
    mq.delete();
    m_und = 0;
    repeat (3) @(negedge clk_sys);
    reset = 0;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic push(input logic [7:0] b);
    logic ok;
    @(negedge clk_sys);
    ok = mq.size() < DEPTH;
    check("wr_ready", wr_ready, ok);
    wr_data = b;
    wr_valid = 1;
    @(negedge clk_sys);
    wr_valid = 0;
    if (ok) mq.push_back(b);
  endtask

  task automatic push_wait(input logic [7:0] b);
    int t = 0;
    @(negedge clk_sys);
    wr_data = b;
    wr_valid = 1;
    while (!wr_ready && t < 3000) begin
      @(negedge clk_sys);
      t++;
    end
    if (t >= 3000) check("push_wait_timeout", 0, 1);
    @(negedge clk_sys);
    wr_valid = 0;
    mq.push_back(b);
  endtask

  task automatic sck_bit(input logic b);
    @(negedge clk_sys);
    spi_di = b;
    repeat (H) @(negedge clk_sys);
    spi_sck = 1;
    repeat (H) @(negedge clk_sys);
    spi_sck = 0;
  endtask

  // Model: a recognised command loads a response at its last bit and after every full response byte;
  // only completed response bytes reach the MCU, any later load is lost when SS rises.
  task automatic model(input logic [7:0] cmd, input int nbits);
    int nb = nbits / 8;
    logic rep = 0;
    logic [7:0] b;
    for (int k = 0; k <= nb; k++) begin
      if (cmd == 8'h55) begin
        if (k > 0 && rep) m_und = 0;
        b = {m_und, 7'(mq.size() > 127 ? 127 : mq.size())};
        rep = m_und;
      end else if (cmd == 8'h56) begin
        if (mq.size() > 0) b = mq.pop_front();
        else begin
          b = 8'h00;
          m_und = 1;
        end
      end else b = 8'h00;
      if (k < nb) exq.push_back(b);
    end
  endtask

  task automatic xfer(input logic [7:0] cmd, input int nbits, input logic chk = 1);
    model(cmd, nbits);
    @(negedge clk_sys);
    spi_ss_n = 0;
    repeat (H) @(negedge clk_sys);
    if (chk) check("spi_do_oe_on", spi_do_oe, 1);
    for (int i = 7; i >= 0; i--) sck_bit(cmd[i]);
    rx_en = 1;
    for (int i = 0; i < nbits; i++) sck_bit(1'($urandom));
    repeat (H) @(negedge clk_sys);
    rx_en = 0;
    spi_ss_n = 1;
    repeat (H) @(negedge clk_sys);
    if (chk) begin
      check("spi_do_oe_off", spi_do_oe, 0);
      check("fifo_level", fifo_level, mq.size());
      check("underrun", underrun, m_und);
    end
  endtask

  initial begin
    do_reset();
    check("rst_do", spi_do, 0);
    check("rst_oe", spi_do_oe, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun, 0);
    for (int i = 0; i < 3; i++) push(8'($urandom));
    xfer(8'h55, 8);
    do_reset();
    push(8'ha5);
    push(8'h3c);
    xfer(8'h56, 16);
    do_reset();
    xfer(8'h56, 8);
    check("underrun_set", underrun, 1);
    xfer(8'h55, 8);
    check("underrun_cleared", underrun, 0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    @(negedge clk_sys);
    check("full_wr_ready", wr_ready, 0);
    push(8'hee);
    check("full_level", fifo_level, DEPTH);
    fork
      xfer(8'h56, 8, 0);
      begin
        push_wait(8'h11);
        push_wait(8'h22);
      end
    join
    repeat (4) @(negedge clk_sys);
    check("level_after_concurrent", fifo_level, DEPTH);
    xfer(8'h56, 8 * DEPTH);
    do_reset();
    push(8'h71);
    push(8'h72);
    xfer(8'h12, 16);
    check("ignore_level", fifo_level, 2);
    do_reset();
    push(8'h81);
    push(8'h82);
    push(8'h83);
    xfer(8'h56, 4);
    xfer(8'h56, 8);
    do_reset();
    for (int r = 0; r < 25; r++) begin
      int np = $urandom_range(0, 6);
      int sel = $urandom_range(0, 2);
      logic [7:0] c = sel == 0 ? 8'h55 : sel == 1 ? 8'h56 : 8'($urandom);
      for (int i = 0; i < np; i++) push(8'($urandom));
      xfer(c, $urandom_range(0, 24));
    end
    do_reset();
    push(8'h91);
    push(8'h92);
    @(negedge clk_sys);
    spi_ss_n = 0;
    repeat (H) @(negedge clk_sys);
    for (int i = 7; i >= 0; i--) sck_bit(i == 1 || i == 2 || i == 4 || i == 6);
    sck_bit(1);
    sck_bit(0);
    spi_sck = 1;
    repeat (3) @(negedge clk_sys);
    reset = 1;
    #1;
    check("midrst_do", spi_do, 0);
    check("midrst_oe", spi_do_oe, 0);
    check("midrst_wr_ready", wr_ready, 1);
    check("midrst_level", fifo_level, 0);
    check("midrst_underrun", underrun, 0);
    spi_sck = 0;
    spi_ss_n = 1;
    mq.delete();
    m_und = 0;
    repeat (3) @(negedge clk_sys);
    reset = 0;
    repeat (3) @(negedge clk_sys);
    check("scoreboard_drained", exq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
